// File: rtl/ram_dma_arbiter_pkg.sv
// Shared constants for the RAM DMA read-port arbiter.
package ram_dma_arbiter_pkg;

  // Arbiter state encodings (2-bit)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Flattened per-requester buses: requester idx occupies [slice_lo(idx,wid) +: wid]
  function automatic int slice_lo(input int idx, input int wid);
    return idx * wid;
  endfunction

endpackage

// File: rtl/ram_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_pick #(
  parameter int NUM_REQ     = 3,
  parameter int NUM_REQ_SIZ = 2
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ_SIZ-1:0] last,
  output logic [NUM_REQ-1:0]     pick,
  output logic [NUM_REQ_SIZ-1:0] idx,
  output logic                   any
);

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins
  always_comb begin
    logic [NUM_REQ_SIZ-1:0] c;
    c    = '0;
    idx  = '0;
    any  = 1'b0;
    pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = NUM_REQ_SIZ'((int'(last) + k) % NUM_REQ);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    for (int j = 0; j < NUM_REQ; j++)
      pick[j] = any && (idx == NUM_REQ_SIZ'(j));
  end

endmodule

// File: rtl/ram_dma_arbiter.sv
// Shares the single RAM DMA read port between NUM_REQ single-word requesters.
// One transaction in flight, round-robin per word.
module ram_dma_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int NUM_REQ_SIZ  = 2,
  parameter int RAM_WID      = 32,
  parameter int RAM_WORD_WID = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*RAM_WID-1:0] req_addr,
  input  logic [NUM_REQ-1:0]         req_read,
  output logic [RAM_WORD_WID-1:0]    req_word,
  output logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [RAM_WID-1:0]         ram_dma_addr,
  output logic                       ram_read,
  input  logic [RAM_WORD_WID-1:0]    ram_word,
  input  logic                       ram_valid
);
  import ram_dma_arbiter_pkg::*;

  logic [1:0]              state_q, state_d;
  logic [NUM_REQ_SIZ-1:0]  last_q, last_d;
  logic [NUM_REQ_SIZ-1:0]  gidx_q, gidx_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      valid_q, valid_d;
  logic [RAM_WID-1:0]      addr_q, addr_d;
  logic                    read_q, read_d;
  logic [RAM_WORD_WID-1:0] word_q, word_d;

  logic [NUM_REQ-1:0]      pick;
  logic [NUM_REQ_SIZ-1:0]  pick_idx;
  logic                    pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ), .NUM_REQ_SIZ(NUM_REQ_SIZ)) u_pick (
    .req  (req_read),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next-state: grant in IDLE, wait for RAM in ISSUE, wait for both sides to drop in RELEASE
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    read_d  = read_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          addr_d  = req_addr[slice_lo(int'(pick_idx), RAM_WID) +: RAM_WID];
          read_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ram_valid) begin
          word_d  = ram_word;
          read_d  = 1'b0;
          // An aborted request still lets the RAM finish, but gets no valid
          if (req_read[gidx_q]) valid_d = grant_q;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!req_read[gidx_q] && !ram_valid) begin
          valid_d = '0;
          grant_d = '0;
          last_d  = gidx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 as top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= NUM_REQ_SIZ'(NUM_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      word_q  <= word_d;
    end
  end

  assign req_word     = word_q;
  assign req_valid    = valid_q;
  assign grant        = grant_q;
  assign ram_dma_addr = addr_q;
  assign ram_read     = read_q;

`ifndef SYNTHESIS
  // Structural invariants of the grant/valid/read outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant_q));
      assert ((valid_q & ~grant_q) == '0);
      assert (!read_q || (grant_q != '0));
    end
  end
`endif

endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Bench for ram_dma_arbiter: handshake-following requesters, a RAM responder
// with programmable latency/hold, and a cycle-level expectation model.
module tb_ram_dma_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [95:0]   req_addr;
  logic [2:0]    req_read;
  logic [15:0]   req_word;
  logic [2:0]    req_valid;
  logic [2:0]    grant;
  logic [31:0]   ram_dma_addr;
  logic          ram_read;
  logic [15:0]   ram_word = 16'h0;
  logic          ram_valid = 1'b0;

  always #5 clk = ~clk;

  ram_dma_arbiter #(.NUM_REQ(3), .NUM_REQ_SIZ(2), .RAM_WID(32), .RAM_WORD_WID(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_addr     (req_addr),
    .req_read     (req_read),
    .req_word     (req_word),
    .req_valid    (req_valid),
    .grant        (grant),
    .ram_dma_addr (ram_dma_addr),
    .ram_read     (ram_read),
    .ram_word     (ram_word),
    .ram_valid    (ram_valid)
  );

  // RAM contents: a fixed function of the address
  function automatic logic [15:0] ram_fn(input logic [31:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  // Round-robin rule: first pending requester after 'last', wrapping
  function automatic int rr(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // RAM responder: valid after rlat cycles of ram_read, held rhold cycles after read drops
  int rlat = 3, rhold = 0, rcnt = 0, rhcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      ram_valid = 1'b0; rcnt = 0; rhcnt = 0;
    end else if (ram_read && !ram_valid) begin
      rcnt = rcnt + 1;
      if (rcnt >= rlat) begin
        ram_valid = 1'b1; ram_word = ram_fn(ram_dma_addr); rcnt = 0; rhcnt = 0;
      end
    end else if (!ram_read && ram_valid) begin
      if (rhcnt >= rhold) ram_valid = 1'b0;
      else rhcnt = rhcnt + 1;
    end
  end

  int npass = 0, nfail = 0, ntot = 0;

  task automatic ck(input string tag, input logic [63:0] o, input logic [63:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Requester intent, addresses, and model state
  logic [2:0]  want = 3'b000;
  logic [31:0] addrs [3];
  bit          rnd_addr = 1'b0;
  logic [2:0]  p_read = 3'b000;
  logic [31:0] p_addr [3];
  logic        p_rv = 1'b0;
  int          phase = 0;   // 0 port free, 1 word outstanding, 2 waiting for release
  int          mlast = 2;
  int          g = 0;
  logic [31:0] maddr = 32'h0;
  logic [15:0] mword = 16'h0;
  logic [2:0]  vexp = 3'b000;
  int          order [$];

  // One clock: check what the last edge should have produced, then drive the next inputs
  task automatic tick();
    logic p_rst;
    p_rst = rst;
    @(negedge clk); #1;
    if (p_rst) begin
      ck("rst_grant", grant, 0); ck("rst_valid", req_valid, 0);
      ck("rst_read", ram_read, 0); ck("rst_addr", ram_dma_addr, 0);
      mword = 16'h0; phase = 0; mlast = 2;
    end else begin
      case (phase)
        0: begin
          g = rr(p_read, mlast);
          if (g >= 0) begin
            maddr = p_addr[g];
            order.push_back(g);
            ck("grant_new", grant, 64'(1) << g);
            ck("read_issue", ram_read, 1);
            ck("addr_issue", ram_dma_addr, maddr);
            ck("valid_issue", req_valid, 0);
            phase = 1;
          end else begin
            ck("idle_grant", grant, 0);
            ck("idle_read", ram_read, 0);
            ck("idle_valid", req_valid, 0);
          end
        end
        1: begin
          ck("busy_grant", grant, 64'(1) << g);
          if (p_rv) begin
            mword = ram_fn(maddr);
            vexp  = p_read[g] ? 3'(1 << g) : 3'b000;
            ck("done_read", ram_read, 0);
            ck("done_valid", req_valid, vexp);
            phase = 2;
          end else begin
            ck("busy_read", ram_read, 1);
            ck("busy_addr", ram_dma_addr, maddr);
            ck("busy_valid", req_valid, 0);
          end
        end
        default: begin
          if (!p_read[g] && !p_rv) begin
            ck("rel_grant", grant, 0);
            ck("rel_valid", req_valid, 0);
            mlast = g; phase = 0;
          end else begin
            ck("hold_grant", grant, 64'(1) << g);
            ck("hold_valid", req_valid, vexp);
            ck("hold_read", ram_read, 0);
          end
        end
      endcase
    end
    ck("word", req_word, mword);
    // Requesters: drop read while valid is shown, otherwise follow intent
    for (int i = 0; i < 3; i++) begin
      logic nr;
      nr = want[i] && !req_valid[i];
      if (nr && !req_read[i] && rnd_addr) addrs[i] = $urandom;
      req_read[i] = nr;
      req_addr[i*32 +: 32] = addrs[i];
      p_addr[i] = addrs[i];
    end
    p_read = req_read;
    p_rv   = ram_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic drain();
    want = 3'b000;
    for (int n = 0; n < 60 && (grant != 0 || ram_valid); n++) tick();
    ck("drain", grant, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; req_read = 3'b000; req_addr = '0;
    for (int i = 0; i < 3; i++) begin addrs[i] = 32'h0; p_addr[i] = 32'h0; end
    tick(); tick();
    rst = 1'b0;

    // Single requester
    addrs[1] = 32'h100; want = 3'b010; rlat = 3;
    tick(); tick();
    ck("t1_read", ram_read, 1); ck("t1_addr", ram_dma_addr, 32'h100); ck("t1_grant", grant, 3'b010);
    for (int n = 0; n < 20 && req_valid == 0; n++) tick();
    ck("t1_valid", req_valid, 3'b010); ck("t1_word", req_word, 16'hBEEF);
    want = 3'b000;
    for (int n = 0; n < 20 && grant != 0; n++) tick();
    ck("t1_clear", grant, 0);
    tick();

    // Round-robin with all three requesting
    do_reset();
    addrs[0] = 32'h0; addrs[1] = 32'h10; addrs[2] = 32'h20; rlat = 2;
    order.delete(); want = 3'b111;
    for (int n = 0; n < 200 && order.size() < 6; n++) tick();
    ck("rr_count", order.size() >= 6, 1);
    for (int k = 0; k < 6 && k < order.size(); k++) ck("rr_order", order[k], k % 3);
    drain();

    // Abort: requester 2 drops read before the RAM answers
    do_reset();
    addrs[2] = 32'h2000; rlat = 5; want = 3'b100;
    for (int n = 0; n < 10 && grant == 0; n++) tick();
    ck("ab_grant", grant, 3'b100);
    want = 3'b011; tick();
    for (int n = 0; n < 20 && ram_read; n++) tick();
    ck("ab_valid", req_valid, 0); ck("ab_word", req_word, ram_fn(32'h2000));
    for (int n = 0; n < 20 && grant != 0; n++) tick();
    for (int n = 0; n < 20 && grant == 0; n++) tick();
    ck("ab_next", grant, 3'b001);
    drain();

    // Slow release: RAM keeps valid high after read drops
    do_reset();
    rlat = 2; rhold = 4; want = 3'b111;
    for (int n = 0; n < 20 && !(grant != 0 && !ram_read); n++) tick();
    ck("sr_done", grant, 3'b001);
    for (int n = 0; n < 20 && ram_valid; n++) begin tick(); if (ram_valid) ck("sr_hold", grant, 3'b001); end
    for (int n = 0; n < 10 && (grant == 0 || grant == 3'b001); n++) tick();
    ck("sr_next", grant, 3'b010);
    rhold = 0;
    drain();

    // Reset in the middle of an outstanding read
    do_reset();
    rlat = 8; want = 3'b101;
    for (int n = 0; n < 10 && !ram_read; n++) tick();
    ck("mr_busy", grant, 3'b001);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    ck("mr_read", ram_read, 0); ck("mr_grant", grant, 0); ck("mr_valid", req_valid, 0);
    tick();
    ck("mr_first", grant, 3'b001);
    rlat = 2;
    drain();

    // Address change during an outstanding read is ignored
    do_reset();
    rlat = 4; addrs[0] = 32'h400; want = 3'b001;
    for (int n = 0; n < 10 && grant == 0; n++) tick();
    addrs[0] = 32'h4444; tick(); tick();
    ck("ac_addr", ram_dma_addr, 32'h400);
    for (int n = 0; n < 20 && req_valid == 0; n++) tick();
    ck("ac_word", req_word, ram_fn(32'h400));
    drain();

    // Randomized traffic, including aborts and varied RAM timing
    do_reset();
    rnd_addr = 1'b1;
    for (int n = 0; n < 600; n++) begin
      rlat  = $urandom_range(1, 4);
      rhold = $urandom_range(0, 2);
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) == 0) want[i] = ~want[i];
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
